// File: rtl/pwm_sequencer.sv
// Table-driven PWM sequencer: plays DEPTH-entry settings table into a pwm block.
// Ports: clk/reset, cfg_* table write, num_entries/loop_en/start/stop control,
// pwm_* settings with one-cycle pwm_update strobe, busy/cur_index/done status.
module pwm_sequencer #(
  parameter int WAVE_LEN_WIDTH = 8,
  parameter int DEPTH          = 8,
  parameter int DUR_WIDTH      = 16,
  localparam int IDX_WIDTH     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [IDX_WIDTH-1:0]      cfg_addr,
  input  logic [WAVE_LEN_WIDTH-1:0] cfg_wave_length,
  input  logic [WAVE_LEN_WIDTH-1:0] cfg_pulse_width,
  input  logic                      cfg_active_high,
  input  logic [DUR_WIDTH-1:0]      cfg_duration,
  input  logic [IDX_WIDTH:0]        num_entries,
  input  logic                      loop_en,
  input  logic                      start,
  input  logic                      stop,
  output logic                      pwm_update,
  output logic [WAVE_LEN_WIDTH-1:0] pwm_wave_length,
  output logic [WAVE_LEN_WIDTH-1:0] pwm_pulse_width,
  output logic                      pwm_active_high,
  output logic                      pwm_enable,
  output logic                      busy,
  output logic [IDX_WIDTH-1:0]      cur_index,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [IDX_WIDTH:0] DEPTH_N = (IDX_WIDTH+1)'(DEPTH);

  logic [WAVE_LEN_WIDTH-1:0] tbl_wl  [DEPTH];
  logic [WAVE_LEN_WIDTH-1:0] tbl_pw  [DEPTH];
  logic                      tbl_ah  [DEPTH];
  logic [DUR_WIDTH-1:0]      tbl_dur [DEPTH];

  state_t                    state_q, state_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [DUR_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      fin;
  logic [IDX_WIDTH:0]        eff_n;
  logic                      more;

  logic                      upd_d, en_d, done_d;
  logic [WAVE_LEN_WIDTH-1:0] wl_q, wl_d, pw_q, pw_d;
  logic                      ah_q, ah_d;
  logic                      upd_q, en_q, done_q;

  // Table is deliberately not reset so a sequence survives a reset.
  always_ff @(posedge clk) begin
    if (cfg_we && ({1'b0, cfg_addr} < DEPTH_N)) begin
      tbl_wl[cfg_addr]  <= cfg_wave_length;
      tbl_pw[cfg_addr]  <= cfg_pulse_width;
      tbl_ah[cfg_addr]  <= cfg_active_high;
      tbl_dur[cfg_addr] <= cfg_duration;
    end
  end

  assign eff_n = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
  assign more  = ({1'b0, idx_q} + (IDX_WIDTH+1)'(1)) < eff_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the cycles left in the entry after the current one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && eff_n != '0) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
        LOAD, HOLD: begin
          if (cnt_q == '0) begin
            if (more) begin
              idx_d   = idx_q + IDX_WIDTH'(1);
              state_d = LOAD;
            end else if (loop_en && eff_n != '0) begin
              idx_d   = '0;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
              fin     = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q - DUR_WIDTH'(1);
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == LOAD) begin
      cnt_d = (tbl_dur[idx_d] == '0) ? '0 : tbl_dur[idx_d] - DUR_WIDTH'(1);
    end
  end

  // Outputs are computed from the next state so they register with it;
  // the table read here sees pre-write contents on a same-edge write.
  always_comb begin
    upd_d  = (state_d == LOAD);
    en_d   = (state_d != IDLE);
    done_d = fin;
    wl_d   = wl_q;
    pw_d   = pw_q;
    ah_d   = ah_q;
    if (upd_d) begin
      wl_d = tbl_wl[idx_d];
      pw_d = tbl_pw[idx_d];
      ah_d = tbl_ah[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_q  <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      wl_q   <= '0;
      pw_q   <= '0;
      ah_q   <= 1'b0;
    end else begin
      upd_q  <= upd_d;
      en_q   <= en_d;
      done_q <= done_d;
      wl_q   <= wl_d;
      pw_q   <= pw_d;
      ah_q   <= ah_d;
    end
  end

  assign pwm_update      = upd_q;
  assign pwm_enable      = en_q;
  assign busy            = en_q;
  assign done            = done_q;
  assign pwm_wave_length = wl_q;
  assign pwm_pulse_width = pw_q;
  assign pwm_active_high = ah_q;
  assign cur_index       = idx_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Scoreboard bench for pwm_sequencer: stimulus pushes expected update/done
// events with their cycle numbers, a negedge monitor pops and compares.
module tb_pwm_sequencer;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wave_length;
  logic [7:0] cfg_pulse_width;
  logic       cfg_active_high;
  logic [15:0] cfg_duration;
  logic [3:0] num_entries;
  logic       loop_en;
  logic       start;
  logic       stop;
  logic       pwm_update;
  logic [7:0] pwm_wave_length;
  logic [7:0] pwm_pulse_width;
  logic       pwm_active_high;
  logic       pwm_enable;
  logic       busy;
  logic [2:0] cur_index;
  logic       done;

  pwm_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wave_length (cfg_wave_length),
    .cfg_pulse_width (cfg_pulse_width),
    .cfg_active_high (cfg_active_high),
    .cfg_duration    (cfg_duration),
    .num_entries     (num_entries),
    .loop_en         (loop_en),
    .start           (start),
    .stop            (stop),
    .pwm_update      (pwm_update),
    .pwm_wave_length (pwm_wave_length),
    .pwm_pulse_width (pwm_pulse_width),
    .pwm_active_high (pwm_active_high),
    .pwm_enable      (pwm_enable),
    .busy            (busy),
    .cur_index       (cur_index),
    .done            (done)
  );

  typedef struct {
    bit is_done;
    int cyc;
    int idx;
    int wl;
    int pw;
    int ah;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", n, cyc, act, req);
    end
  endfunction

  function automatic void push_upd(int c, int i, int wl, int pw, int ah);
    exp_t e;
    e.is_done = 1'b0;
    e.cyc = c;
    e.idx = i;
    e.wl = wl;
    e.pw = pw;
    e.ah = ah;
    sb.push_back(e);
  endfunction

  function automatic void push_done(int c);
    exp_t e;
    e.is_done = 1'b1;
    e.cyc = c;
    e.idx = 0;
    e.wl = 0;
    e.pw = 0;
    e.ah = 0;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!reset && (pwm_update || done)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d upd=%0b done=%0b required=none",
                 cyc, pwm_update, done);
      end else begin
        mon_e = sb.pop_front();
        chk("evt_cycle", cyc, mon_e.cyc);
        chk("evt_is_done", int'(done), int'(mon_e.is_done));
        if (!mon_e.is_done) begin
          chk("upd_index", int'(cur_index), mon_e.idx);
          chk("upd_wave", int'(pwm_wave_length), mon_e.wl);
          chk("upd_pulse", int'(pwm_pulse_width), mon_e.pw);
          chk("upd_ah", int'(pwm_active_high), mon_e.ah);
          chk("upd_enable", int'(pwm_enable), 1);
        end else begin
          chk("done_enable", int'(pwm_enable), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) tick();
  endtask

  task automatic write_entry(int a, int wl, int pw, int ah, int d);
    cfg_addr        = 3'(a);
    cfg_wave_length = 8'(wl);
    cfg_pulse_width = 8'(pw);
    cfg_active_high = ah[0];
    cfg_duration    = 16'(d);
    cfg_we          = 1'b1;
    tick();
    cfg_we          = 1'b0;
  endtask

  task automatic do_start(output int t);
    t = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, "_upd"}, int'(pwm_update), 0);
    chk({tag, "_en"}, int'(pwm_enable), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_idx"}, int'(cur_index), 0);
    chk({tag, "_wave"}, int'(pwm_wave_length), 0);
    chk({tag, "_pulse"}, int'(pwm_pulse_width), 0);
    chk({tag, "_ah"}, int'(pwm_active_high), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tt;
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wave_length = '0;
    cfg_pulse_width = '0;
    cfg_active_high = 1'b0;
    cfg_duration = '0;
    num_entries = '0;
    loop_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_cleared("reset");

    // Two-entry run, with an ignored start while busy
    write_entry(0, 10, 5, 1, 20);
    write_entry(1, 20, 18, 1, 30);
    num_entries = 4'd2;
    loop_en = 1'b0;
    do_start(t);
    push_upd(t + 1, 0, 10, 5, 1);
    push_upd(t + 21, 1, 20, 18, 1);
    push_done(t + 51);
    wait_cyc(t + 10);
    do_start(tt);
    wait_drain(100);
    tick();
    chk("oneshot_en_after", int'(pwm_enable), 0);
    chk("oneshot_busy_after", int'(busy), 0);

    // Looping run, stopped inside entry 0 of the third pass
    loop_en = 1'b1;
    do_start(t);
    push_upd(t + 1, 0, 10, 5, 1);
    push_upd(t + 21, 1, 20, 18, 1);
    push_upd(t + 51, 0, 10, 5, 1);
    push_upd(t + 71, 1, 20, 18, 1);
    push_upd(t + 101, 0, 10, 5, 1);
    wait_cyc(t + 105);
    do_stop();
    chk("loop_stop_en", int'(pwm_enable), 0);
    chk("loop_stop_busy", int'(busy), 0);
    wait_drain(5);
    repeat (30) tick();

    // Stop five cycles into entry 1, then restart from entry 0
    loop_en = 1'b0;
    do_start(t);
    push_upd(t + 1, 0, 10, 5, 1);
    push_upd(t + 21, 1, 20, 18, 1);
    wait_cyc(t + 26);
    do_stop();
    chk("stop_e1_en", int'(pwm_enable), 0);
    chk("stop_e1_done", int'(done), 0);
    wait_drain(5);
    repeat (40) tick();
    do_start(t);
    push_upd(t + 1, 0, 10, 5, 1);
    push_upd(t + 21, 1, 20, 18, 1);
    push_done(t + 51);
    wait_drain(100);

    // Zero entries: start is ignored
    num_entries = 4'd0;
    do_start(t);
    repeat (10) tick();
    chk("zero_n_busy", int'(busy), 0);
    chk("zero_n_en", int'(pwm_enable), 0);

    // Duration 0 looping single entry, rewritten mid-run
    write_entry(0, 7, 3, 0, 0);
    num_entries = 4'd1;
    loop_en = 1'b1;
    do_start(t);
    for (int i = 1; i <= 6; i++) push_upd(t + i, 0, 7, 3, 0);
    for (int i = 7; i <= 10; i++) push_upd(t + i, 0, 9, 4, 1);
    wait_cyc(t + 5);
    write_entry(0, 9, 4, 1, 0);
    wait_cyc(t + 10);
    do_stop();
    wait_drain(5);
    chk("dur0_en_after", int'(pwm_enable), 0);
    repeat (5) tick();

    // num_entries above DEPTH plays all 8 entries
    for (int i = 0; i < 8; i++) write_entry(i, 4 + 3 * i, i + 1, i & 1, i + 2);
    num_entries = 4'd15;
    loop_en = 1'b0;
    do_start(t);
    tt = t + 1;
    for (int i = 0; i < 8; i++) begin
      push_upd(tt, i, 4 + 3 * i, i + 1, i & 1);
      tt += i + 2;
    end
    push_done(tt);
    wait_drain(200);
    tick();
    chk("n15_en_after", int'(pwm_enable), 0);

    // Asynchronous reset mid-hold, then replay of the unchanged table
    write_entry(0, 10, 5, 1, 20);
    write_entry(1, 20, 18, 1, 30);
    num_entries = 4'd2;
    do_start(t);
    push_upd(t + 1, 0, 10, 5, 1);
    wait_cyc(t + 10);
    #3;
    reset = 1'b1;
    #1;
    chk_cleared("async_rst");
    wait_drain(2);
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_start(t);
    push_upd(t + 1, 0, 10, 5, 1);
    push_upd(t + 21, 1, 20, 18, 1);
    push_done(t + 51);
    wait_drain(100);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
